point_write_scheduler: RTL

POINT_WRITE_SCHEDULER -- requirements
Module: point_write_scheduler

---
 rtl/rfb_pkg.sv | 26 ++
 rtl/point_fifo.sv | 50 +++++
 rtl/point_write_scheduler.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/rfb_pkg.sv
// Shared rotating-frame-buffer definitions: geometry defaults, the point record and
// the write scheduler state encoding, common to the scheduler and the frame buffer.
package rfb_pkg;

    localparam int ROTATIONAL_RES_DEF = 1024;
    localparam int DISPLAY_RADIUS_DEF = 32;
    localparam int DISPLAY_HEIGHT_DEF = 64;

    localparam int RADIUS_W = $clog2(DISPLAY_RADIUS_DEF);
    localparam int THETA_W  = $clog2(ROTATIONAL_RES_DEF);
    localparam int Z_W      = $clog2(DISPLAY_HEIGHT_DEF);

    typedef struct packed {
        logic                flush;
        logic [RADIUS_W-1:0] radius;
        logic [THETA_W-1:0]  theta;
        logic [Z_W-1:0]      z;
    } point_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FLUSH_WAIT = 2'd1,
        WRITE_WAIT = 2'd2
    } sched_state_t;

endpackage

// File: rtl/point_fifo.sv
// First-word-fall-through point FIFO; the scheduler may clear the flag (MSB) of the
// head entry in place so a pending flush is consumed without losing the point.
module point_fifo #(
    parameter int DATA_W = 22,
    parameter int DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [DATA_W-1:0]      wdata,
    input  logic                   pop,
    input  logic                   clear_flag,
    output logic [DATA_W-1:0]      rdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wdata;
        if (clear_flag)
            mem[rd_ptr][DATA_W-1] <= 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/point_write_scheduler.sv
// Drains queued points into the frame buffer one at a time, honouring its busy handshake.
// Optional WRITE_DEDUP_EN drops a point identical to the last write issued since a flush.
module point_write_scheduler
    import rfb_pkg::*;
#(
    parameter int ROTATIONAL_RES = ROTATIONAL_RES_DEF,
    parameter int DISPLAY_RADIUS = DISPLAY_RADIUS_DEF,
    parameter int DISPLAY_HEIGHT = DISPLAY_HEIGHT_DEF,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              point_valid_in,
    output logic                              point_ready_out,
    input  logic                              point_flush_in,
    input  logic [$clog2(DISPLAY_RADIUS)-1:0] radius_in,
    input  logic [$clog2(ROTATIONAL_RES)-1:0] theta_in,
    input  logic [$clog2(DISPLAY_HEIGHT)-1:0] z_in,
    input  logic                              buf_busy_in,
    output logic                              buf_flush_out,
    output logic                              buf_new_data_out,
    output logic [$clog2(DISPLAY_RADIUS)-1:0] buf_radius_out,
    output logic [$clog2(ROTATIONAL_RES)-1:0] buf_theta_out,
    output logic [$clog2(DISPLAY_HEIGHT)-1:0] buf_z_out,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_count_out,
    output logic [15:0]                       write_count_out,
    output logic [15:0]                       dup_count_out
);

    localparam int RW = $clog2(DISPLAY_RADIUS);
    localparam int TW = $clog2(ROTATIONAL_RES);
    localparam int ZW = $clog2(DISPLAY_HEIGHT);
    localparam int DW = 1 + RW + TW + ZW;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    sched_state_t  state;
    logic          holdoff;
    logic [DW-1:0] head;
    logic          push;
    logic          issue_ok;
    logic          do_flush;
    logic          do_pop;
    logic          do_write;
    logic          is_dup;

    assign point_ready_out = rst_in && (fifo_count_out < DEPTH_C);
    assign push            = point_valid_in && point_ready_out;

    // The FIFO stores {flush, radius, theta, z} with the flush flag as its MSB.
    point_fifo #(
        .DATA_W (DW),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk_in),
        .rst_n      (rst_in),
        .push       (push),
        .wdata      ({point_flush_in, radius_in, theta_in, z_in}),
        .pop        (do_pop),
        .clear_flag (do_flush),
        .rdata      (head),
        .count      (fifo_count_out)
    );

    assign issue_ok = (state == IDLE) && (fifo_count_out != '0) && !buf_busy_in;
    assign do_flush = issue_ok && head[DW-1];
    assign do_pop   = issue_ok && !head[DW-1];
    assign do_write = do_pop && !is_dup;

`ifdef WRITE_DEDUP_EN
    logic                 last_valid;
    logic [RW+TW+ZW-1:0]  last_point;

    assign is_dup = last_valid && (head[DW-2:0] == last_point);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            last_valid    <= 1'b0;
            last_point    <= '0;
            dup_count_out <= '0;
        end else begin
            if (do_flush)
                last_valid <= 1'b0;
            else if (do_write) begin
                last_valid <= 1'b1;
                last_point <= head[DW-2:0];
            end
            if (do_pop && is_dup && dup_count_out != 16'hFFFF)
                dup_count_out <= dup_count_out + 16'd1;
        end
    end
`else
    assign is_dup        = 1'b0;
    assign dup_count_out = '0;
`endif

    // Pulses last one cycle; the wait states skip busy for that pulse cycle, since the
    // buffer only raises busy in response to it.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state            <= IDLE;
            holdoff          <= 1'b0;
            buf_flush_out    <= 1'b0;
            buf_new_data_out <= 1'b0;
            buf_radius_out   <= '0;
            buf_theta_out    <= '0;
            buf_z_out        <= '0;
            write_count_out  <= '0;
        end else begin
            buf_flush_out    <= 1'b0;
            buf_new_data_out <= 1'b0;
            buf_radius_out   <= '0;
            buf_theta_out    <= '0;
            buf_z_out        <= '0;
            case (state)
                IDLE: begin
                    if (do_flush) begin
                        state         <= FLUSH_WAIT;
                        holdoff       <= 1'b1;
                        buf_flush_out <= 1'b1;
                    end else if (do_write) begin
                        state            <= WRITE_WAIT;
                        holdoff          <= 1'b1;
                        buf_new_data_out <= 1'b1;
                        buf_radius_out   <= head[DW-2 -: RW];
                        buf_theta_out    <= head[TW+ZW-1 -: TW];
                        buf_z_out        <= head[ZW-1:0];
                        if (write_count_out != 16'hFFFF)
                            write_count_out <= write_count_out + 16'd1;
                    end
                end
                FLUSH_WAIT, WRITE_WAIT: begin
                    if (holdoff)
                        holdoff <= 1'b0;
                    else if (!buf_busy_in)
                        state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    holdoff <= 1'b0;
                end
            endcase
        end
    end

endmodule
